vector_mem_unit: RTL
====================

Name: vector_mem_unit

Overview:
Vector load/store stage that sits directly downstream of the vector ALU. On store, it captures the ALU's 8-lane result vector and serializes it into a scalar WIDTH-bit data memory, one lane per cycle. On load, it gathers VECTOR_WIDTH scalar words from memory into a vector, which it presents atomically to the register-file write-back. Addressing is strided, so the vector datapath can reach scalar memory.

Parameters:
WIDTH, 24, bits per lane and per memory word
VECTOR_WIDTH, 8, lanes per vector
ADDR_WIDTH, 16, word-address width of data memory

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  operation request; accepted only in IDLE
op  in  1  0 = load, 1 = store; sampled at accept
base_addr  in  ADDR_WIDTH  word address of lane 0; sampled at accept
stride  in  ADDR_WIDTH  unsigned word stride between lanes; sampled at accept
store_data  in  [VECTOR_WIDTH-1:0][WIDTH-1:0]  vector from ALU Out; captured at accept
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at operation completion
load_data  out  [VECTOR_WIDTH-1:0][WIDTH-1:0]  last completed load vector
mem_addr  out  ADDR_WIDTH  memory word address
mem_we  out  1  memory write strobe
mem_re  out  1  memory read strobe
mem_wdata  out  WIDTH  memory write data
mem_rdata  in  WIDTH  read data; valid exactly 1 cycle after mem_re (synchronous RAM)

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: state = IDLE; busy, done, mem_we, mem_re = 0; mem_addr, mem_wdata = 0; load_data = all zeros; internal staging and index registers = 0.
- States: IDLE, STORE, LOAD, LOAD_LAST, DONE.
- Accept: at a rising edge with state == IDLE and start == 1, register op, base_addr, stride, and store_data (all lanes). Set idx = 0 and addr = base_addr.
  - op = 1 goes to STORE.
  - op = 0 goes to LOAD.
- Address generation: addr is an accumulator; each advancing edge applies addr += stride, modulo 2^ADDR_WIDTH (wrap is silent). Lane i address = base_addr + i*stride mod 2^ADDR_WIDTH.
- STORE:
  - Each cycle drives mem_we = 1, mem_addr = addr, mem_wdata = captured lane[idx].
  - idx increments each edge.
  - At the edge where idx == VECTOR_WIDTH-1, go to DONE.
- LOAD:
  - Each cycle drives mem_re = 1, mem_addr = addr.
  - Each edge records a capture tag (cap_valid = 1, cap_idx = idx).
  - When cap_valid is set, staging[cap_idx] <= mem_rdata.
  - At the edge where idx == VECTOR_WIDTH-1, go to LOAD_LAST.
- LOAD_LAST: no memory strobe; captures the final lane (VECTOR_WIDTH-1) into staging. Next state is DONE, and load_data <= full staging vector on that same edge.
- DONE: done = 1 for exactly one cycle; next state is IDLE.
- load_data never shows a partially loaded vector. It holds its value through stores and until the next load completes.
- mem_we and mem_re are never high together. In IDLE and DONE, both strobes are 0 and mem_addr / mem_wdata are 0.
- Latency, with accept at edge E0:
  - Store: writes in cycles 1..VECTOR_WIDTH; done in cycle VECTOR_WIDTH+1; next accept possible at the following edge.
  - Load: reads in cycles 1..VECTOR_WIDTH; LOAD_LAST in cycle VECTOR_WIDTH+1; done and new load_data visible in cycle VECTOR_WIDTH+2.
- start while busy (including DONE) is ignored, not queued. store_data changes after accept have no effect.
- stride = 0: every lane targets base_addr. A store leaves lane[VECTOR_WIDTH-1] in memory; a load replicates one word into all lanes.
- rst asserted mid-operation aborts immediately to the reset values. Any memory writes already issued are not undone.

Decomposition:
- Shared package vector_pkg:
  - WIDTH / VECTOR_WIDTH / ADDR_WIDTH defaults
  - vmem_state_t enum (IDLE, STORE, LOAD, LOAD_LAST, DONE)
  - op constants VMEM_LOAD = 1'b0, VMEM_STORE = 1'b1
  - vector_t typedef [VECTOR_WIDTH-1:0][WIDTH-1:0]
- One sub-module is natural: vmem_addr_gen, the strided address accumulator with load/advance controls and a last-lane flag. All else stays inline.

Test Plan:
- Store, base 0x0010, stride 1, lanes 0x000001..0x000008 (lane 0 = 1) -> mem_we in cycles 1..8 at addresses 0x0010..0x0017 with matching data; done pulse in cycle 9; busy low in cycle 10.
- Load, base 0x0100, stride 2, memory model mem[0x100 + 2i] = 0xA00000 + i -> reads at 0x100, 0x102, .., 0x10E; load_data stays at its old value through cycle 9; in cycle 10, done = 1 and load_data lane i = 0xA00000 + i.
- Wrap, store at base 0xFFFE, stride 1 -> write addresses 0xFFFE, 0xFFFF, 0x0000..0x0005 in order.
- stride 0 store of lanes 0x11..0x88 to 0x0040 -> eight writes to 0x0040, final memory value 0x000088. A subsequent load -> all lanes 0x000088.
- start with new store_data pulsed in cycles 3 and 9 of an ongoing store -> ignored; writes carry only the originally captured data; exactly one done pulse.
- rst asserted in cycle 4 of a load -> all outputs 0 immediately and load_data = 0; after release, a fresh load completes normally with correct data.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared types and sizing for the vector load/store stage.
// Lane vectors are packed so they can be passed whole between the ALU, this unit and write-back.
package vector_pkg;

    localparam int WIDTH        = 24;
    localparam int VECTOR_WIDTH = 8;
    localparam int ADDR_WIDTH   = 16;
    localparam int IDX_WIDTH    = $clog2(VECTOR_WIDTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STORE     = 3'd1,
        LOAD      = 3'd2,
        LOAD_LAST = 3'd3,
        DONE      = 3'd4
    } vmem_state_t;

    localparam logic VMEM_LOAD  = 1'b0;
    localparam logic VMEM_STORE = 1'b1;

    typedef logic [VECTOR_WIDTH-1:0][WIDTH-1:0] vector_t;

endpackage

// File: rtl/vmem_addr_gen.sv
// Strided address accumulator: loads base/stride on accept, then steps one lane per advance.
// Address arithmetic wraps silently at 2^ADDR_WIDTH.
module vmem_addr_gen
    import vector_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  advance,
    input  logic [ADDR_WIDTH-1:0] baseAddr,
    input  logic [ADDR_WIDTH-1:0] stride,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [IDX_WIDTH-1:0]  idx,
    output logic                  lastLane
);

    logic [ADDR_WIDTH-1:0] strideReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            strideReg <= '0;
            idx       <= '0;
        end else if (load) begin
            addr      <= baseAddr;
            strideReg <= stride;
            idx       <= '0;
        end else if (advance) begin
            addr <= addr + strideReg;
            idx  <= idx + 1'b1;
        end
    end

    assign lastLane = (idx == IDX_WIDTH'(VECTOR_WIDTH - 1));

endmodule

// File: rtl/vector_mem_unit.sv
// Vector load/store stage: serializes ALU vectors into scalar memory and gathers
// strided scalar words back into a vector that is published only when complete.
module vector_mem_unit
    import vector_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  vector_t               store_data,
    output logic                  busy,
    output logic                  done,
    output vector_t               load_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata
);

    vmem_state_t           state;
    vmem_state_t           nextState;
    vector_t               storeLanes;
    vector_t               staging;
    vector_t               mergedStaging;
    logic                  capValid;
    logic [IDX_WIDTH-1:0]  capIdx;
    logic [ADDR_WIDTH-1:0] curAddr;
    logic [IDX_WIDTH-1:0]  curIdx;
    logic                  lastLane;
    logic                  accept;
    logic                  advance;

    assign accept  = (state == IDLE) && start;
    assign advance = (state == STORE) || (state == LOAD);

    vmem_addr_gen u_addrGen (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .advance  (advance),
        .baseAddr (base_addr),
        .stride   (stride),
        .addr     (curAddr),
        .idx      (curIdx),
        .lastLane (lastLane)
    );

    always_comb begin
        nextState = state;
        case (state)
            IDLE:      if (start) nextState = (op == VMEM_STORE) ? STORE : LOAD;
            STORE:     if (lastLane) nextState = DONE;
            LOAD:      if (lastLane) nextState = LOAD_LAST;
            LOAD_LAST: nextState = DONE;
            DONE:      nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    // Read data returns one cycle after its strobe, so each capture is tagged with
    // the lane that was addressed on the previous cycle.
    always_comb begin
        mergedStaging = staging;
        if (capValid) mergedStaging[capIdx] = mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            storeLanes <= '0;
            staging    <= '0;
            capValid   <= 1'b0;
            capIdx     <= '0;
            load_data  <= '0;
        end else begin
            state    <= nextState;
            capValid <= (state == LOAD);
            capIdx   <= curIdx;
            staging  <= mergedStaging;
            if (accept) storeLanes <= store_data;
            // Publish including the final lane arriving this cycle, so no partial vector is ever visible.
            if (state == LOAD_LAST) load_data <= mergedStaging;
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        mem_we    = (state == STORE);
        mem_re    = (state == LOAD);
        mem_addr  = advance ? curAddr : '0;
        mem_wdata = (state == STORE) ? storeLanes[curIdx] : '0;
    end

endmodule
